// File: rtl/psum_accumulator.sv
// Multi-row, multi-lane partial-sum accumulator for a systolic array.
// Rows accumulate with saturation and are drained through a valid/ready port, optionally as a cross-lane sum.
module psum_accumulator #(
  parameter int ARR_SIZE = 4,
  parameter int IN_W     = 32,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 32,
  parameter int DEPTH    = 16,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ARR_SIZE*IN_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic                      in_first,
  input  logic                      drain_req,
  input  logic [ADDR_W-1:0]         drain_base,
  input  logic [ADDR_W:0]           drain_len,
  input  logic                      sum_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ARR_SIZE*OUT_W-1:0] out_data,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      drain_done,
  output logic                      ovf,
  output logic                      state_dbg
);

  // Both ports use valid/ready: a beat transfers on the rising edge where valid && ready.
  // The producer keeps data stable while valid is high and ready is low.

  localparam int SUM_W = ACC_W + $clog2(ARR_SIZE);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         ptr;
  logic [ADDR_W:0]           cnt;
  logic                      smode;
  logic signed [ACC_W-1:0]   acc [DEPTH][ARR_SIZE];

  logic                      accept;
  logic                      out_hs;
  logic [ARR_SIZE*ACC_W-1:0] upd_flat;
  logic [ARR_SIZE-1:0]       upd_sat;
  logic [ARR_SIZE*OUT_W-1:0] lane_out;
  logic signed [SUM_W-1:0]   red_sum;
  logic [OUT_W-1:0]          red_out;

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] c;
    if (v > OUT_MAX)      c = OUT_MAX;
    else if (v < OUT_MIN) c = OUT_MIN;
    else                  c = v;
    return c[OUT_W-1:0];
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DRAIN);
  assign state_dbg = (state == DRAIN);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_addr  = (state == DRAIN) ? ptr : '0;

  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    logic signed [ACC_W:0]   ext_in;
    logic signed [ACC_W:0]   ext_acc;
    logic signed [ACC_W:0]   sum;
    logic signed [SUM_W-1:0] rd_ext;
    logic                    wrap;

    assign ext_in  = (ACC_W+1)'($signed(in_data[k*IN_W +: IN_W]));
    assign ext_acc = (ACC_W+1)'(acc[in_addr][k]);
    assign sum     = ext_acc + ext_in;
    // One extra bit of headroom: the top two bits disagree exactly when ACC_W overflows.
    assign wrap    = sum[ACC_W] != sum[ACC_W-1];
    assign upd_sat[k] = !in_first && wrap;
    assign upd_flat[k*ACC_W +: ACC_W] = in_first ? ext_in[ACC_W-1:0] :
                                        wrap ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) :
                                        sum[ACC_W-1:0];

    assign rd_ext = SUM_W'(acc[ptr][k]);
    assign lane_out[k*OUT_W +: OUT_W] = sat_out(rd_ext);
  end

  always_comb begin
    red_sum = '0;
    for (int k = 0; k < ARR_SIZE; k++) red_sum = red_sum + SUM_W'(acc[ptr][k]);
  end

  assign red_out = sat_out(red_sum);

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      if (smode) out_data[OUT_W-1:0] = red_out;
      else       out_data = lane_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      smode      <= 1'b0;
      drain_done <= 1'b0;
      ovf        <= 1'b0;
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < ARR_SIZE; k++) acc[r][k] <= '0;
    end else begin
      drain_done <= 1'b0;
      if (accept) begin
        for (int k = 0; k < ARR_SIZE; k++) acc[in_addr][k] <= upd_flat[k*ACC_W +: ACC_W];
        if (|upd_sat) ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (drain_req) begin
            ptr   <= drain_base;
            cnt   <= (drain_len == '0) ? (ADDR_W+1)'(DEPTH) : drain_len;
            smode <= sum_mode;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            for (int k = 0; k < ARR_SIZE; k++) acc[ptr][k] <= '0;
            ptr <= (ptr == ADDR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (cnt == (ADDR_W+1)'(1)) begin
              state      <= IDLE;
              drain_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus randomized traffic against an arithmetic row model.
module tb_psum_accumulator;

  localparam int ARR_SIZE = 4;
  localparam int IN_W     = 32;
  localparam int ACC_W    = 40;
  localparam int OUT_W    = 32;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int DIN      = ARR_SIZE*IN_W;
  localparam int DOUT     = ARR_SIZE*OUT_W;
  localparam longint A_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint A_MIN = -(longint'(1) << (ACC_W-1));
  localparam longint O_MAX = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint O_MIN = -(longint'(1) << (OUT_W-1));

  logic              clk, rst;
  logic              in_valid, in_ready, in_first;
  logic [DIN-1:0]    in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              drain_req, sum_mode;
  logic [ADDR_W-1:0] drain_base;
  logic [ADDR_W:0]   drain_len;
  logic              out_valid, out_ready, drain_done, ovf, state_dbg;
  logic [DOUT-1:0]   out_data;
  logic [ADDR_W-1:0] out_addr;

  psum_accumulator #(.ARR_SIZE(ARR_SIZE), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr), .in_first(in_first),
    .drain_req(drain_req), .drain_base(drain_base), .drain_len(drain_len), .sum_mode(sum_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .drain_done(drain_done), .ovf(ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  longint          model_acc [DEPTH][ARR_SIZE];
  bit              model_ovf;
  logic [DOUT-1:0] exp_q[$];
  int              addr_q[$];
  int              checks, errors;

  task automatic check(input string tag, input logic [DOUT-1:0] got, input logic [DOUT-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic logic [DIN-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [DIN-1:0] r;
    r = {d, c, b, a};
    return r;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < ARR_SIZE; k++) model_acc[r][k] = 0;
    model_ovf = 0;
  endtask

  task automatic model_beat(input int addr, input bit first, input logic [DIN-1:0] d);
    for (int k = 0; k < ARR_SIZE; k++) begin
      longint x, v;
      x = longint'($signed(d[k*IN_W +: IN_W]));
      v = first ? x : model_acc[addr][k] + x;
      if (v > A_MAX || v < A_MIN) model_ovf = 1;
      model_acc[addr][k] = clamp(v, A_MIN, A_MAX);
    end
  endtask

  function automatic logic [DOUT-1:0] model_out(input int addr, input bit mode);
    logic [DOUT-1:0] r;
    longint s;
    r = '0;
    if (mode) begin
      s = 0;
      for (int k = 0; k < ARR_SIZE; k++) s += model_acc[addr][k];
      s = clamp(s, O_MIN, O_MAX);
      r[OUT_W-1:0] = s[OUT_W-1:0];
    end else begin
      for (int k = 0; k < ARR_SIZE; k++) begin
        s = clamp(model_acc[addr][k], O_MIN, O_MAX);
        r[k*OUT_W +: OUT_W] = s[OUT_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [DIN-1:0] rand_data();
    logic [DIN-1:0] r;
    for (int k = 0; k < ARR_SIZE; k++) begin
      if ($urandom_range(0, 3) == 0) r[k*IN_W +: IN_W] = $urandom;
      else r[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 2000)) - 1000);
    end
    return r;
  endfunction

  // driver tasks
  task automatic beat(input int addr, input bit first, input logic [DIN-1:0] d);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_addr = ADDR_W'(addr); in_first = first; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(addr, first, d);
  endtask

  // rmode: 0 = always ready, 1 = ready toggles 1,0,1,0..., 2 = random
  task automatic drain(input int base, input int len, input bit mode, input int rmode,
                       input bit do_beat, input int b_addr, input bit b_first, input logic [DIN-1:0] b_data);
    int n, phase, stalls;
    bit r, stalled;
    logic [DOUT-1:0] prev;
    @(negedge clk);
    check("in_ready_pre_drain", in_ready, 1'b1);
    drain_req = 1'b1; drain_base = ADDR_W'(base); drain_len = (ADDR_W+1)'(len); sum_mode = mode;
    if (do_beat) begin
      in_valid = 1'b1; in_addr = ADDR_W'(b_addr); in_first = b_first; in_data = b_data;
    end
    @(posedge clk); #1;
    drain_req = 1'b0; in_valid = 1'b0;
    if (do_beat) model_beat(b_addr, b_first, b_data);
    n = (len == 0) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_out((base + i) % DEPTH, mode));
      addr_q.push_back((base + i) % DEPTH);
    end
    phase = 0; stalls = 0; stalled = 0; prev = '0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("in_ready_drain", in_ready, 1'b0);
      check("out_valid_drain", out_valid, 1'b1);
      check("out_addr", out_addr, addr_q[0]);
      check("out_data", out_data, exp_q[0]);
      if (stalled) check("out_data_stable", out_data, prev);
      prev = out_data;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (phase % 2 == 0);
        default: r = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      phase++;
      out_ready = r;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (r) begin
        for (int k = 0; k < ARR_SIZE; k++) model_acc[addr_q[0]][k] = 0;
        void'(exp_q.pop_front());
        void'(addr_q.pop_front());
        stalls = 0; stalled = 0;
      end else begin
        stalls++; stalled = 1;
      end
    end
    @(negedge clk);
    check("drain_done_pulse", drain_done, 1'b1);
    check("out_valid_after", out_valid, 1'b0);
    check("out_data_idle", out_data, '0);
    check("in_ready_after", in_ready, 1'b1);
    check("ovf", ovf, model_ovf);
    @(negedge clk);
    check("drain_done_once", drain_done, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 0; in_first = 0; in_data = '0; in_addr = '0;
    drain_req = 0; drain_base = '0; drain_len = '0; sum_mode = 0; out_ready = 0;
    model_reset();

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_drain_done", drain_done, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_addr", out_addr, '0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1'b1);

    // accumulation into row 3, then drain and confirm the row was cleared
    beat(3, 1, pack4(1, 2, 3, 4));
    beat(3, 0, pack4(10, -20, 30, -40));
    drain(3, 1, 0, 0, 0, 0, 0, '0);
    drain(3, 1, 0, 0, 0, 0, 0, '0);

    // back-pressure across the wrap from row 15 to row 0
    beat(14, 1, rand_data()); beat(15, 1, rand_data());
    beat(0, 1, rand_data());  beat(1, 1, rand_data());
    drain(14, 4, 0, 1, 0, 0, 0, '0);

    // cross-lane reduction
    beat(9, 1, pack4(100, 200, -50, 7));
    drain(9, 1, 1, 0, 0, 0, 0, '0);

    // beat and drain request in the same cycle on the same row
    beat(5, 1, pack4(5, 6, 7, 8));
    drain(5, 1, 0, 2, 1, 5, 0, pack4(1, 1, 1, 1));

    // saturation: 256 adds stay in range, the 257th clamps
    beat(7, 1, pack4(32'h7FFFFFFF, 0, 0, 0));
    for (int i = 1; i < 256; i++) beat(7, 0, pack4(32'h7FFFFFFF, 0, 0, 0));
    @(negedge clk) check("ovf_before_sat", ovf, 1'b0);
    for (int i = 256; i < 512; i++) beat(7, 0, pack4(32'h7FFFFFFF, 0, 0, 0));
    @(negedge clk) check("ovf_after_sat", ovf, 1'b1);
    check("model_clamp", 1'(model_acc[7][0] == A_MAX), 1'b1);
    drain(7, 1, 0, 0, 0, 0, 0, '0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0)
        beat($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)), rand_data());
      else
        drain($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH), 1'($urandom_range(0, 1)), 2,
              1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)), rand_data());
    end

    // reset in the middle of a stalled 8-row drain
    for (int r = 0; r < 8; r++) beat(r, 1, rand_data());
    @(negedge clk);
    drain_req = 1'b1; drain_base = '0; drain_len = 5'd8; sum_mode = 1'b0;
    @(posedge clk); #1;
    drain_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, model_out(0, 0));
    end
    rst = 1'b1;
    in_valid = 1'b1; in_addr = 4'd5; in_first = 1'b1; in_data = pack4(9, 9, 9, 9); drain_req = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_drain_done", drain_done, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_out_addr", out_addr, '0);
    check("midrst_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; drain_req = 1'b0;
    model_reset();
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    drain(5, 1, 0, 0, 0, 0, 0, '0);
    drain(0, 0, 0, 2, 0, 0, 0, '0);

    // traffic after reset
    for (int it = 0; it < 10; it++) beat($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)), rand_data());
    drain($urandom_range(0, DEPTH-1), 0, 1'($urandom_range(0, 1)), 2, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
